// File: rtl/parking_gate_ctrl.sv
// Multi-slot parking gate: password entry with lockout,
// occupancy counting and a two-digit 7-segment readout.
module parking_gate_ctrl #(
  parameter int                  CAPACITY       = 8,
  parameter int                  PW_WIDTH       = 4,
  parameter logic [PW_WIDTH-1:0] PASSWORD       = 4'hA,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  TIMEOUT_CYCLES = 32,
  parameter int                  LOCK_CYCLES    = 16,
  localparam int                 OW = $clog2(CAPACITY + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sensor_entrance,
  input  logic                sensor_exit,
  input  logic [PW_WIDTH-1:0] password,
  input  logic                pw_valid,
  output logic                gate_open,
  output logic                GREEN_LED,
  output logic                RED_LED,
  output logic [OW-1:0]       occupancy,
  output logic                full,
  output logic                locked,
  output logic [6:0]          HEX_1,
  output logic [6:0]          HEX_2
);

  localparam int TW  = $clog2(MAX_TRIES + 1);
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LKW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WRONG,
    S_RIGHT,
    S_LOCK
  } state_t;

  state_t         state;
  logic [TW-1:0]  tries;
  logic [TMW-1:0] tmr;
  logic [LKW-1:0] lock_cnt;
  logic           exit_prev;
  logic           inc;
  logic           dec;
  logic [6:0]     occ7;
  logic [3:0]     tens;
  logic [3:0]     ones;

  assign inc  = (state == S_RIGHT) && !sensor_entrance;
  assign dec  = sensor_exit && !exit_prev;
  assign full = (occupancy == OW'(CAPACITY));

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Entry FSM with retry/timeout/lockout counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tries     <= '0;
      tmr       <= '0;
      lock_cnt  <= '0;
      gate_open <= 1'b0;
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (sensor_entrance && !full) begin
            state   <= S_WAIT;
            tries   <= '0;
            tmr     <= '0;
            RED_LED <= 1'b1;
          end
        end
        S_WAIT, S_WRONG: begin
          if (pw_valid) begin
            if (password == PASSWORD) begin
              state     <= S_RIGHT;
              RED_LED   <= 1'b0;
              GREEN_LED <= 1'b1;
              gate_open <= 1'b1;
            end else if (tries + TW'(1) == TW'(MAX_TRIES)) begin
              state    <= S_LOCK;
              lock_cnt <= '0;
              RED_LED  <= 1'b1;
              locked   <= 1'b1;
            end else begin
              state   <= S_WRONG;
              tries   <= tries + TW'(1);
              tmr     <= '0;
              RED_LED <= (state == S_WAIT) ? 1'b1 : ~RED_LED;
            end
          end else if (tmr == TMW'(TIMEOUT_CYCLES - 1)) begin
            state   <= S_IDLE;
            RED_LED <= 1'b0;
          end else begin
            tmr <= tmr + TMW'(1);
            if (state == S_WRONG) RED_LED <= ~RED_LED;
          end
        end
        S_RIGHT: begin
          if (!sensor_entrance) begin
            state     <= S_IDLE;
            GREEN_LED <= 1'b0;
            gate_open <= 1'b0;
          end
        end
        S_LOCK: begin
          if (lock_cnt == LKW'(LOCK_CYCLES - 1)) begin
            state   <= S_IDLE;
            tries   <= '0;
            RED_LED <= 1'b0;
            locked  <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + LKW'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          gate_open <= 1'b0;
          GREEN_LED <= 1'b0;
          RED_LED   <= 1'b0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

  // Saturating occupancy counter; entry and exit together cancel out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
      exit_prev <= 1'b0;
    end else begin
      exit_prev <= sensor_exit;
      if (inc && !dec && occupancy != OW'(CAPACITY))
        occupancy <= occupancy + OW'(1);
      else if (dec && !inc && occupancy != '0)
        occupancy <= occupancy - OW'(1);
    end
  end

  // Split occupancy into decimal digits for the active-low display
  always_comb begin
    occ7  = 7'(occupancy);
    tens  = 4'(occ7 / 7'd10);
    ones  = 4'(occ7 % 7'd10);
    HEX_1 = seg7(tens);
    HEX_2 = seg7(ones);
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl:
// entry, wrong tries, lockout, timeout, capacity, exits, reset.
module tb_parking_gate_ctrl;

  logic       clk;
  logic       reset_n;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [3:0] password;
  logic       pw_valid;
  logic       gate_open;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [3:0] occupancy;
  logic       full;
  logic       locked;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;

  int n_vec;
  int n_bad;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG5 = 7'b0010010;
  localparam logic [6:0] SEG7 = 7'b1111000;
  localparam logic [6:0] SEG8 = 7'b0000000;

  parking_gate_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .password        (password),
    .pw_valid        (pw_valid),
    .gate_open       (gate_open),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .occupancy       (occupancy),
    .full            (full),
    .locked          (locked),
    .HEX_1           (HEX_1),
    .HEX_2           (HEX_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic admit();
    sensor_entrance = 1'b1;
    step(1);
    pw_valid = 1'b1;
    password = 4'hA;
    step(1);
    pw_valid = 1'b0;
    sensor_entrance = 1'b0;
    step(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gate"},   32'(gate_open), 32'd0);
    check({tag, "_green"},  32'(GREEN_LED), 32'd0);
    check({tag, "_red"},    32'(RED_LED),   32'd0);
    check({tag, "_occ"},    32'(occupancy), 32'd0);
    check({tag, "_full"},   32'(full),      32'd0);
    check({tag, "_locked"}, 32'(locked),    32'd0);
    check({tag, "_hex1"},   32'(HEX_1),     32'(SEG0));
    check({tag, "_hex2"},   32'(HEX_2),     32'(SEG0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset_n = 1'b0;
    sensor_entrance = 1'b0;
    sensor_exit = 1'b0;
    password = 4'h0;
    pw_valid = 1'b0;
    step(2);
    check_reset_vals("rst");
    reset_n = 1'b1;
    step(1);

    // correct password admits one car
    sensor_entrance = 1'b1;
    step(1);
    check("wait_red", 32'(RED_LED), 32'd1);
    check("wait_green", 32'(GREEN_LED), 32'd0);
    step(2);
    pw_valid = 1'b1;
    password = 4'hA;
    step(1);
    pw_valid = 1'b0;
    check("right_green", 32'(GREEN_LED), 32'd1);
    check("right_gate", 32'(gate_open), 32'd1);
    check("right_red", 32'(RED_LED), 32'd0);
    check("right_occ", 32'(occupancy), 32'd0);
    sensor_entrance = 1'b0;
    step(1);
    check("adm1_gate", 32'(gate_open), 32'd0);
    check("adm1_green", 32'(GREEN_LED), 32'd0);
    check("adm1_occ", 32'(occupancy), 32'd1);
    check("adm1_hex1", 32'(HEX_1), 32'(SEG0));
    check("adm1_hex2", 32'(HEX_2), 32'(SEG1));

    // three wrong passwords lead to lockout
    sensor_entrance = 1'b1;
    step(1);
    sensor_entrance = 1'b0;
    pw_valid = 1'b1;
    password = 4'h3;
    step(1);
    pw_valid = 1'b0;
    check("wrong1_red", 32'(RED_LED), 32'd1);
    check("wrong1_locked", 32'(locked), 32'd0);
    step(1);
    check("wrong_tog0", 32'(RED_LED), 32'd0);
    step(1);
    check("wrong_tog1", 32'(RED_LED), 32'd1);
    pw_valid = 1'b1;
    password = 4'h5;
    step(1);
    check("wrong2_locked", 32'(locked), 32'd0);
    password = 4'h7;
    step(1);
    pw_valid = 1'b0;
    check("lock_locked", 32'(locked), 32'd1);
    check("lock_red", 32'(RED_LED), 32'd1);
    pw_valid = 1'b1;
    password = 4'hA;
    sensor_entrance = 1'b1;
    step(1);
    pw_valid = 1'b0;
    sensor_entrance = 1'b0;
    check("lock_ign_locked", 32'(locked), 32'd1);
    check("lock_ign_green", 32'(GREEN_LED), 32'd0);
    check("lock_ign_gate", 32'(gate_open), 32'd0);
    step(14);
    check("lock_last", 32'(locked), 32'd1);
    step(1);
    check("lock_end", 32'(locked), 32'd0);
    check("lock_end_red", 32'(RED_LED), 32'd0);
    check("lock_end_occ", 32'(occupancy), 32'd1);

    // timeout after exactly 32 idle cycles in WAIT_PASSWORD
    sensor_entrance = 1'b1;
    step(1);
    sensor_entrance = 1'b0;
    step(31);
    check("tmo_31_red", 32'(RED_LED), 32'd1);
    step(1);
    check("tmo_32_red", 32'(RED_LED), 32'd0);
    check("tmo_occ", 32'(occupancy), 32'd1);

    // recovery from WRONG_PASS with the right password
    sensor_entrance = 1'b1;
    step(1);
    pw_valid = 1'b1;
    password = 4'h3;
    step(1);
    check("rec_wrong_red", 32'(RED_LED), 32'd1);
    password = 4'hA;
    step(1);
    pw_valid = 1'b0;
    check("rec_green", 32'(GREEN_LED), 32'd1);
    check("rec_red", 32'(RED_LED), 32'd0);
    sensor_entrance = 1'b0;
    step(1);
    check("rec_occ", 32'(occupancy), 32'd2);

    // fill to capacity
    for (int i = 0; i < 6; i++) admit();
    check("full_occ", 32'(occupancy), 32'd8);
    check("full_flag", 32'(full), 32'd1);
    check("full_hex1", 32'(HEX_1), 32'(SEG0));
    check("full_hex2", 32'(HEX_2), 32'(SEG8));
    sensor_entrance = 1'b1;
    step(2);
    check("full_refuse_red", 32'(RED_LED), 32'd0);
    check("full_refuse_occ", 32'(occupancy), 32'd8);
    sensor_entrance = 1'b0;

    // one exit edge, held level counts once
    sensor_exit = 1'b1;
    step(1);
    check("exit_occ", 32'(occupancy), 32'd7);
    check("exit_full", 32'(full), 32'd0);
    check("exit_hex2", 32'(HEX_2), 32'(SEG7));
    step(9);
    check("exit_held_occ", 32'(occupancy), 32'd7);
    sensor_exit = 1'b0;
    step(1);

    // entry completion and exit edge on the same clock
    sensor_entrance = 1'b1;
    step(1);
    pw_valid = 1'b1;
    password = 4'hA;
    step(1);
    pw_valid = 1'b0;
    sensor_entrance = 1'b0;
    sensor_exit = 1'b1;
    step(1);
    check("simul_occ", 32'(occupancy), 32'd7);
    check("simul_gate", 32'(gate_open), 32'd0);
    sensor_exit = 1'b0;
    step(1);

    // drain and exit at zero
    for (int i = 0; i < 7; i++) begin
      sensor_exit = 1'b1;
      step(1);
      sensor_exit = 1'b0;
      step(1);
    end
    check("drain_occ", 32'(occupancy), 32'd0);
    sensor_exit = 1'b1;
    step(1);
    sensor_exit = 1'b0;
    step(1);
    check("zero_exit_occ", 32'(occupancy), 32'd0);
    check("zero_exit_hex2", 32'(HEX_2), 32'(SEG0));

    // asynchronous reset in RIGHT_PASS with five cars inside
    for (int i = 0; i < 5; i++) admit();
    check("five_occ", 32'(occupancy), 32'd5);
    check("five_hex2", 32'(HEX_2), 32'(SEG5));
    sensor_entrance = 1'b1;
    step(1);
    pw_valid = 1'b1;
    password = 4'hA;
    step(1);
    pw_valid = 1'b0;
    check("pre_rst_gate", 32'(gate_open), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    sensor_entrance = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
